gem_kchar_gen: RTL and testbench

Transmit-side emulator for the GEM optohybrid fiber K-character stream. Generates per-bunch-crossing 8-bit K-character words for four fibers (two per GEM chamber), with programmable per-fiber skew and one-shot corruption injection. Sits in the GEM loopback/self-test path and feeds the `gemN_kchar` inputs of the GEM sync monitor, so every monitor flag can be driven deterministically.

---
 rtl/gem_pkg.sv | 21 ++
 rtl/gem_kchar_gen_if.sv | 33 +++
 rtl/gem_kchar_dly.sv | 36 +++
 rtl/gem_kchar_gen.sv | 128 ++++++++++++
 tb/tb_gem_kchar_gen.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/gem_pkg.sv
// Shared constants and types for the GEM K-character generator.
// Holds the character set, the default orbit length and the generator state enum.
package gem_pkg;

  localparam logic [7:0] K_IDLE   = 8'hBC;
  localparam logic [7:0] K_RESYNC = 8'h3C;
  localparam logic [7:0] K_BC0    = 8'h7C;

  // Rotating character, indexed by bxn[1:0].
  localparam logic [3:0][7:0] K_ROT = {8'hFD, 8'hFB, 8'hF7, 8'hBC};

  localparam int BXN_MAX_DEF = 3563;
  localparam int NUM_FIBERS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESYNC,
    ST_RUN
  } gem_state_e;

endpackage

// File: rtl/gem_kchar_gen_if.sv
// Control and fiber bus of the GEM K-character generator.
// The generator is the slave side; the test/loopback controller is the master side.
interface gem_kchar_gen_if;

  logic        run;
  logic        ttc_resync;
  logic        skew_wr;
  logic [2:0]  skew0;
  logic [2:0]  skew1;
  logic [2:0]  skew2;
  logic [2:0]  skew3;
  logic        inj_err;
  logic [3:0]  inj_mask;
  logic [7:0]  gem0_kchar;
  logic [7:0]  gem1_kchar;
  logic [7:0]  gem2_kchar;
  logic [7:0]  gem3_kchar;
  logic [11:0] bxn;
  logic        bc0;
  logic        running;
  logic [15:0] inj_cnt;

  modport slave (
    input  run, ttc_resync, skew_wr, skew0, skew1, skew2, skew3, inj_err, inj_mask,
    output gem0_kchar, gem1_kchar, gem2_kchar, gem3_kchar, bxn, bc0, running, inj_cnt
  );

  modport master (
    output run, ttc_resync, skew_wr, skew0, skew1, skew2, skew3, inj_err, inj_mask,
    input  gem0_kchar, gem1_kchar, gem2_kchar, gem3_kchar, bxn, bc0, running, inj_cnt
  );

endinterface

// File: rtl/gem_kchar_dly.sv
// Per-fiber skew line: tap 0 is the live input, taps 1..7 are past inputs,
// and the selected tap is registered once more onto the fiber.
module gem_kchar_dly
  import gem_pkg::*;
(
  input  logic       clock,
  input  logic       global_reset,
  input  logic [7:0] din_i,
  input  logic [2:0] tap_sel_i,
  output logic [7:0] dout_o
);

  logic [7:0] line_q [1:7];
  logic [7:0] dout_q;
  logic [7:0] tap_c;

  always_comb begin
    tap_c = din_i;
    if (tap_sel_i != 3'd0) tap_c = line_q[tap_sel_i];
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      // NOTE: the history is reset too, because after a skew change any old entry can reach the fiber.
      for (int i = 1; i <= 7; i++) line_q[i] <= K_IDLE;
      dout_q <= K_IDLE;
    end else begin
      line_q[1] <= din_i;
      for (int i = 2; i <= 7; i++) line_q[i] <= line_q[i-1];
      dout_q <= tap_c;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/gem_kchar_gen.sv
// GEM optohybrid K-character stream emulator: IDLE/RESYNC/RUN sequencer, injection, per-fiber skew.
// Define GEM_KCHAR_SKEW_EN to build the skew registers and delay lines; otherwise latency is fixed at 2.
module gem_kchar_gen
  import gem_pkg::*;
#(
  parameter int BXN_MAX    = BXN_MAX_DEF,
  parameter int RESYNC_LEN = 4
) (
  input  logic            clock,
  input  logic            global_reset,
  gem_kchar_gen_if.slave  bus
);

  gem_state_e state_q, state_d;
  logic [11:0] bxn_q, bxn_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        running_q;
  logic        bc0_q;
  logic [15:0] inj_cnt_q;
  logic [7:0]  base_c;
  logic [NUM_FIBERS-1:0][7:0] s1_q;
  logic [NUM_FIBERS-1:0][7:0] kchar;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    bxn_d   = bxn_q;
    cnt_d   = cnt_q;
    base_c  = K_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        bxn_d = '0;
        if (bus.run) begin
          state_d = ST_RESYNC;
          cnt_d   = '0;
        end
      end
      ST_RESYNC: begin
        base_c = K_RESYNC;
        bxn_d  = '0;
        if (bus.ttc_resync)                   cnt_d   = '0;
        else if (cnt_q == 8'(RESYNC_LEN - 1)) state_d = ST_RUN;
        else                                  cnt_d   = cnt_q + 8'd1;
      end
      ST_RUN: begin
        base_c = (bxn_q == 12'd0) ? K_BC0 : K_ROT[bxn_q[1:0]];
        if (bus.ttc_resync) begin
          state_d = ST_RESYNC;
          cnt_d   = '0;
          bxn_d   = '0;
        end else begin
          bxn_d = (bxn_q == 12'(BXN_MAX)) ? 12'd0 : bxn_q + 12'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Dropping run overrides resync and the normal sequence.
    if (!bus.run) begin
      state_d = ST_IDLE;
      bxn_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      state_q   <= ST_IDLE;
      bxn_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      bc0_q     <= 1'b0;
      inj_cnt_q <= '0;
      s1_q      <= {NUM_FIBERS{K_IDLE}};
    end else begin
      // NOTE: non-blocking assignments so every register here samples the pre-edge values.
      state_q   <= state_d;
      bxn_q     <= bxn_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == ST_RUN);
      bc0_q     <= (base_c == K_BC0);
      if (bus.inj_err && (bus.inj_mask != 4'd0) && (inj_cnt_q != 16'hFFFF))
        inj_cnt_q <= inj_cnt_q + 16'd1;
      for (int n = 0; n < NUM_FIBERS; n++)
        s1_q[n] <= base_c ^ {8{bus.inj_err & bus.inj_mask[n]}};
    end
  end

`ifdef GEM_KCHAR_SKEW_EN
  logic [NUM_FIBERS-1:0][2:0] skew_q;

  always_ff @(posedge clock) begin
    if (global_reset)     skew_q <= '0;
    else if (bus.skew_wr) skew_q <= {bus.skew3, bus.skew2, bus.skew1, bus.skew0};
  end

  for (genvar g = 0; g < NUM_FIBERS; g++) begin : g_fiber
    gem_kchar_dly u_dly (
      .clock        (clock),
      .global_reset (global_reset),
      .din_i        (s1_q[g]),
      .tap_sel_i    (skew_q[g]),
      .dout_o       (kchar[g])
    );
  end
`else
  logic [NUM_FIBERS-1:0][7:0] out_q;
  logic                       unused_skew;

  assign unused_skew = ^{bus.skew_wr, bus.skew0, bus.skew1, bus.skew2, bus.skew3};

  always_ff @(posedge clock) begin
    if (global_reset) out_q <= {NUM_FIBERS{K_IDLE}};
    else              out_q <= s1_q;
  end

  assign kchar = out_q;
`endif

  assign bus.gem0_kchar = kchar[0];
  assign bus.gem1_kchar = kchar[1];
  assign bus.gem2_kchar = kchar[2];
  assign bus.gem3_kchar = kchar[3];
  assign bus.bxn        = bxn_q;
  assign bus.bc0        = bc0_q;
  assign bus.running    = running_q;
  assign bus.inj_cnt    = inj_cnt_q;

endmodule

// File: tb/tb_gem_kchar_gen.sv
// Directed bench for gem_kchar_gen: reset, start-up sequence, orbit wrap, skew, injection,
// mid-orbit resync and reset during RUN; works with or without GEM_KCHAR_SKEW_EN.
module tb_gem_kchar_gen;

  logic clock = 1'b0;
  logic global_reset;

  always #5 clock = ~clock;

  gem_kchar_gen_if bus ();

  gem_kchar_gen #(
    .BXN_MAX    (3563),
    .RESYNC_LEN (4)
  ) dut (
    .clock        (clock),
    .global_reset (global_reset),
    .bus          (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int bx0_cyc  = 0;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected RUN character for a given bunch crossing.
  function automatic logic [7:0] exp_kchar(input int bx);
    logic [7:0] k;
    if (bx == 0) k = 8'h7C;
    else case (bx % 4)
      0:       k = 8'hBC;
      1:       k = 8'hF7;
      2:       k = 8'hFB;
      default: k = 8'hFD;
    endcase
    return k;
  endfunction

  function automatic int bx_at(input int c);
    return (c - bx0_cyc) % 3564;
  endfunction

  function automatic logic [31:0] fibers();
    return {bus.gem3_kchar, bus.gem2_kchar, bus.gem1_kchar, bus.gem0_kchar};
  endfunction

  initial begin
    int t, s, i, p, guard;
    logic [7:0] e, e3;

    global_reset   = 1'b1;
    bus.run        = 1'b0;
    bus.ttc_resync = 1'b0;
    bus.skew_wr    = 1'b0;
    bus.skew0      = 3'd0;
    bus.skew1      = 3'd0;
    bus.skew2      = 3'd0;
    bus.skew3      = 3'd0;
    bus.inj_err    = 1'b0;
    bus.inj_mask   = 4'd0;
    tick();
    tick();
    global_reset = 1'b0;
    repeat (20) tick();

    check("idle_fibers",  fibers(),    32'hBCBCBCBC);
    check("idle_bxn",     bus.bxn,     32'd0);
    check("idle_running", bus.running, 32'd0);
    check("idle_inj_cnt", bus.inj_cnt, 32'd0);
    check("idle_bc0",     bus.bc0,     32'd0);

    // Start-up: 4 RESYNC cycles, then BC0 at bxn 0.
    bus.run = 1'b1;
    t       = cyc;
    bx0_cyc = t + 5;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k <= 2)      e = 8'hBC;
      else if (k <= 6) e = 8'h3C;
      else             e = exp_kchar(bx_at(cyc - 2));
      check($sformatf("start_fibers_k%0d", k), fibers(), {4{e}});
      check($sformatf("start_running_k%0d", k), bus.running, (k >= 5) ? 32'd1 : 32'd0);
      check($sformatf("start_bxn_k%0d", k), bus.bxn, (k >= 5) ? 32'(k - 5) : 32'd0);
      check($sformatf("start_bc0_k%0d", k), bus.bc0, (k == 6) ? 32'd1 : 32'd0);
    end

    // Orbit wrap and BC0 period.
    guard = 0;
    while (bus.bxn !== 12'd3563 && guard < 4000) begin
      tick();
      guard++;
    end
    check("bxn_max_cycle", cyc, bx0_cyc + 3563);
    tick();
    check("bxn_wrap", bus.bxn, 32'd0);
    check("bc0_before_wrap", bus.bc0, 32'd0);
    tick();
    check("bc0_period", bus.bc0, 32'd1);
    check("fibers_at_wrap", fibers(), {4{8'hFD}});
    tick();
    check("fibers_bc0_after_wrap", fibers(), {4{8'h7C}});

`ifdef GEM_KCHAR_SKEW_EN
    // Skew fiber 3 by 3 cycles; new tap is visible two cycles after the write.
    bus.skew3   = 3'd3;
    bus.skew_wr = 1'b1;
    s = cyc;
    tick();
    bus.skew_wr = 1'b0;
    bus.skew3   = 3'd0;
    check("skew_not_yet", fibers(), {4{exp_kchar(bx_at(cyc - 2))}});
    for (int k = 0; k < 8; k++) begin
      tick();
      e  = exp_kchar(bx_at(cyc - 2));
      e3 = exp_kchar(bx_at(cyc - 5));
      check($sformatf("skew3_k%0d", k), fibers(), {e3, e, e, e});
    end
    bus.skew_wr = 1'b1;
    tick();
    bus.skew_wr = 1'b0;
    tick();
    tick();
    check("skew_restored", fibers(), {4{exp_kchar(bx_at(cyc - 2))}});
`else
    // Skew writes are ignored: latency stays 2 and all fibers match.
    bus.skew0   = 3'd7;
    bus.skew1   = 3'd7;
    bus.skew2   = 3'd7;
    bus.skew3   = 3'd7;
    bus.skew_wr = 1'b1;
    s = cyc;
    tick();
    bus.skew_wr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("noskew_k%0d", k), fibers(), {4{exp_kchar(bx_at(cyc - 2))}});
    end
    bus.skew0 = 3'd0;
    bus.skew1 = 3'd0;
    bus.skew2 = 3'd0;
    bus.skew3 = 3'd0;
`endif

    // One-shot injection on fiber 1.
    tick();
    i = cyc;
    bus.inj_err  = 1'b1;
    bus.inj_mask = 4'b0010;
    tick();
    bus.inj_err  = 1'b0;
    bus.inj_mask = 4'b0000;
    check("inj_cnt_one", bus.inj_cnt, 32'd1);
    check("inj_before", fibers(), {4{exp_kchar(bx_at(cyc - 2))}});
    tick();
    e = exp_kchar(bx_at(i));
    check("inj_fiber1", fibers(), {e, e, ~e, e});
    tick();
    check("inj_after", fibers(), {4{exp_kchar(bx_at(cyc - 2))}});

    // Zero mask is not counted.
    bus.inj_err = 1'b1;
    tick();
    bus.inj_err = 1'b0;
    check("inj_cnt_zero_mask", bus.inj_cnt, 32'd1);
    tick();
    check("inj_zero_mask_fibers", fibers(), {4{exp_kchar(bx_at(cyc - 2))}});

    // All-fiber injection.
    i = cyc;
    bus.inj_err  = 1'b1;
    bus.inj_mask = 4'b1111;
    tick();
    bus.inj_err  = 1'b0;
    bus.inj_mask = 4'b0000;
    check("inj_cnt_two", bus.inj_cnt, 32'd2);
    tick();
    check("inj_all", fibers(), {4{~exp_kchar(bx_at(i))}});

    // Mid-orbit resync at bxn 1000.
    guard = 0;
    while (bx_at(cyc) != 1000 && guard < 4000) begin
      tick();
      guard++;
    end
    check("resync_bxn_1000", bus.bxn, 32'd1000);
    p = cyc;
    bus.ttc_resync = 1'b1;
    tick();
    bus.ttc_resync = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 1)      e = exp_kchar(999);
      else if (k == 2) e = exp_kchar(1000);
      else if (k <= 6) e = 8'h3C;
      else             e = 8'h7C;
      check($sformatf("resync_fibers_k%0d", k), fibers(), {4{e}});
      check($sformatf("resync_bxn_k%0d", k), bus.bxn, (k >= 5) ? 32'(k - 5) : 32'd0);
      check($sformatf("resync_running_k%0d", k), bus.running, (k >= 5) ? 32'd1 : 32'd0);
      if (k < 7) tick();
    end
    bx0_cyc = p + 5;

    // Reset during RUN.
    tick();
    global_reset = 1'b1;
    tick();
    check("rst_fibers",  fibers(),    32'hBCBCBCBC);
    check("rst_bxn",     bus.bxn,     32'd0);
    check("rst_running", bus.running, 32'd0);
    check("rst_inj_cnt", bus.inj_cnt, 32'd0);
    check("rst_bc0",     bus.bc0,     32'd0);
    global_reset = 1'b0;
    bus.run      = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
